lane_merger: RTL and testbench

Receive-side stage that consumes the three 8-bit lanes (dataOut0..2 / validOut0..2) produced by the lane-distribution block and merges them into one byte stream. Each lane is buffered in its own small FIFO. A round-robin arbiter drains the FIFOs into a registered output port with a valid/ready handshake. The block flags back-pressure per lane and records any overflow in a sticky error bit.

---
 rtl/lane_merger_if.sv | 42 ++++
 rtl/lane_merger.sv | 144 ++++++++++++++
 tb/tb_lane_merger.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/lane_merger_if.sv
// ============================================================================
// Module      : lane_merger_if
// Description : Lane input / merged output bundle for lane_merger.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lane_merger_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] dataIn0;
    logic [DATA_WIDTH-1:0] dataIn1;
    logic [DATA_WIDTH-1:0] dataIn2;
    logic                  validIn0;
    logic                  validIn1;
    logic                  validIn2;
    logic                  ready_out;
    logic [DATA_WIDTH-1:0] dataOut;
    logic                  validOut;
    logic [1:0]            laneOut;
    logic                  full0;
    logic                  full1;
    logic                  full2;
    logic                  almost_full0;
    logic                  almost_full1;
    logic                  almost_full2;
    logic                  overflow_err;

    modport master (
        output dataIn0, dataIn1, dataIn2, validIn0, validIn1, validIn2, ready_out,
        input  dataOut, validOut, laneOut, full0, full1, full2,
               almost_full0, almost_full1, almost_full2, overflow_err
    );

    modport slave (
        input  dataIn0, dataIn1, dataIn2, validIn0, validIn1, validIn2, ready_out,
        output dataOut, validOut, laneOut, full0, full1, full2,
               almost_full0, almost_full1, almost_full2, overflow_err
    );
endinterface

`default_nettype wire

// File: rtl/lane_merger.sv
// ============================================================================
// Module      : lane_merger
// Description : Buffers three byte lanes in FIFOs and merges them round-robin
//               into one registered valid/ready output stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lane_merger #(
    parameter int DATA_WIDTH  = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int ADDR_WIDTH  = 2,
    parameter int AFULL_LEVEL = 3
) (
    input  logic        clk,
    input  logic        reset,
    lane_merger_if.slave bus
);
    localparam int                  c_LANES = 3;
    localparam logic [ADDR_WIDTH:0] c_DEPTH = (ADDR_WIDTH+1)'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH:0] c_AFULL = (ADDR_WIDTH+1)'(AFULL_LEVEL);

    logic [c_LANES-1:0]    w_valid_in;
    logic [c_LANES-1:0]    w_nonempty;
    logic [c_LANES-1:0]    w_full;
    logic [c_LANES-1:0]    w_afull;
    logic [c_LANES-1:0]    w_pop;
    logic [c_LANES-1:0]    w_drop;
    logic [DATA_WIDTH-1:0] w_data_in [c_LANES];
    logic [DATA_WIDTH-1:0] w_head    [c_LANES];

    logic                  w_load;
    logic                  w_grant_valid;
    logic [1:0]            w_grant_lane;
    logic [1:0]            w_cand;

    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_valid_out;
    logic [1:0]            r_lane_out;
    logic [1:0]            r_ptr;
    logic                  r_overflow;

    assign w_valid_in   = {bus.validIn2, bus.validIn1, bus.validIn0};
    assign w_data_in[0] = bus.dataIn0;
    assign w_data_in[1] = bus.dataIn1;
    assign w_data_in[2] = bus.dataIn2;

    assign w_load = !r_valid_out || bus.ready_out;

    // Search starts one past the last granted lane, so lane order rotates.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_lane  = r_ptr;
        w_cand        = r_ptr;
        for (int k = 0; k < c_LANES; k++) begin
            w_cand = (w_cand == 2'd2) ? 2'd0 : w_cand + 2'd1;
            if (!w_grant_valid && w_nonempty[w_cand]) begin
                w_grant_valid = 1'b1;
                w_grant_lane  = w_cand;
            end
        end
    end

    for (genvar l = 0; l < c_LANES; l++) begin : g_lane
        logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
        logic [ADDR_WIDTH-1:0] r_wr_ptr;
        logic [ADDR_WIDTH-1:0] r_rd_ptr;
        logic [ADDR_WIDTH:0]   r_count;
        logic                  w_push;

        assign w_full[l]     = (r_count == c_DEPTH);
        assign w_afull[l]    = (r_count >= c_AFULL);
        assign w_nonempty[l] = (r_count != '0);
        assign w_pop[l]      = w_load && w_grant_valid && (w_grant_lane == 2'(l));
        // A full lane still accepts when its head leaves in the same cycle.
        assign w_push        = w_valid_in[l] && (!w_full[l] || w_pop[l]);
        assign w_drop[l]     = w_valid_in[l] && !w_push;
        assign w_head[l]     = r_mem[r_rd_ptr];

        always_ff @(posedge clk) begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_data_in[l];
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop[l]) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                if (w_push && !w_pop[l]) begin
                    r_count <= r_count + 1'b1;
                end else if (!w_push && w_pop[l]) begin
                    r_count <= r_count - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
            r_lane_out  <= 2'd0;
            r_ptr       <= 2'd2;
            r_overflow  <= 1'b0;
        end else begin
            if (w_load) begin
                if (w_grant_valid) begin
                    r_data_out  <= w_head[w_grant_lane];
                    r_lane_out  <= w_grant_lane;
                    r_valid_out <= 1'b1;
                    r_ptr       <= w_grant_lane;
                end else begin
                    r_valid_out <= 1'b0;
                end
            end
            if (|w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign bus.dataOut      = r_data_out;
    assign bus.validOut     = r_valid_out;
    assign bus.laneOut      = r_lane_out;
    assign bus.full0        = w_full[0];
    assign bus.full1        = w_full[1];
    assign bus.full2        = w_full[2];
    assign bus.almost_full0 = w_afull[0];
    assign bus.almost_full1 = w_afull[1];
    assign bus.almost_full2 = w_afull[2];
    assign bus.overflow_err = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_lane_merger.sv
// ============================================================================
// Module      : tb_lane_merger
// Description : Directed self-checking bench for lane_merger.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lane_merger;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    lane_merger_if #(.DATA_WIDTH(8)) bus ();

    lane_merger #(
        .DATA_WIDTH (8),
        .FIFO_DEPTH (4),
        .ADDR_WIDTH (2),
        .AFULL_LEVEL(3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] vin;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [7:0] d2;
        logic       rdy;
        logic       ev;
        logic [7:0] ed;
        logic [1:0] el;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [2:0] v, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic r);
        bus.validIn0  = v[0];
        bus.validIn1  = v[1];
        bus.validIn2  = v[2];
        bus.dataIn0   = a;
        bus.dataIn1   = b;
        bus.dataIn2   = c;
        bus.ready_out = r;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl = '{
            '{3'b111, 8'hFF, 8'h15, 8'h37, 1'b1, 1'b0, 8'h00, 2'd0},
            '{3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 2'd0},
            '{3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 8'h15, 2'd1},
            '{3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 8'h37, 2'd2},
            '{3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h37, 2'd2},
            '{3'b010, 8'h00, 8'h51, 8'h00, 1'b0, 1'b0, 8'h37, 2'd2},
            '{3'b000, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h51, 2'd1},
            '{3'b000, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h51, 2'd1},
            '{3'b000, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h51, 2'd1},
            '{3'b000, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h51, 2'd1}
        };

        drive(3'b000, 8'h00, 8'h00, 8'h00, 1'b0);
        reset = 1'b0;
        step();
        step();
        chk("rst_valid", bus.validOut, 0);
        chk("rst_data", bus.dataOut, 0);
        chk("rst_lane", bus.laneOut, 0);
        chk("rst_flags", {bus.full0, bus.full1, bus.full2,
                          bus.almost_full0, bus.almost_full1, bus.almost_full2}, 0);
        chk("rst_ovf", bus.overflow_err, 0);
        reset = 1'b1;
        step();
        chk("post_rst_valid", bus.validOut, 0);

        // Round-robin burst and back-pressure hold
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].vin, tbl[i].d0, tbl[i].d1, tbl[i].d2, tbl[i].rdy);
            step();
            chk($sformatf("vec%0d_valid", i), bus.validOut, tbl[i].ev);
            chk($sformatf("vec%0d_data", i), bus.dataOut, tbl[i].ed);
            chk($sformatf("vec%0d_lane", i), bus.laneOut, tbl[i].el);
        end
        chk("vec_ovf", bus.overflow_err, 0);

        // Lane 0 fill and overflow with the output stalled
        for (int i = 0; i < 6; i++) begin
            drive(3'b001, 8'hA0 + 8'(i), 8'h00, 8'h00, 1'b0);
            step();
            if (i == 1) begin
                chk("ovf_first_out", bus.dataOut, 8'hA0);
                chk("ovf_first_valid", bus.validOut, 1);
            end
            if (i == 2) chk("af0_below", bus.almost_full0, 0);
            if (i == 3) begin
                chk("af0_at3", bus.almost_full0, 1);
                chk("full0_at3", bus.full0, 0);
            end
            if (i == 4) begin
                chk("full0_at4", bus.full0, 1);
                chk("ovf_before_drop", bus.overflow_err, 0);
            end
            if (i == 5) begin
                chk("ovf_set", bus.overflow_err, 1);
                chk("full0_after_drop", bus.full0, 1);
                chk("ovf_hold_data", bus.dataOut, 8'hA0);
            end
        end
        for (int j = 1; j <= 4; j++) begin
            drive(3'b000, 8'h00, 8'h00, 8'h00, 1'b1);
            step();
            chk($sformatf("drain0_data%0d", j), bus.dataOut, 8'hA0 + 8'(j));
            chk($sformatf("drain0_valid%0d", j), bus.validOut, 1);
            chk($sformatf("drain0_lane%0d", j), bus.laneOut, 0);
        end
        step();
        chk("drain0_empty", bus.validOut, 0);
        chk("ovf_sticky", bus.overflow_err, 1);

        // Asynchronous reset with bytes queued on lane 1
        for (int i = 0; i < 4; i++) begin
            drive(3'b010, 8'h00, 8'hC0 + 8'(i), 8'h00, 1'b0);
            step();
        end
        chk("pre_rst_af1", bus.almost_full1, 1);
        chk("pre_rst_data", bus.dataOut, 8'hC0);
        drive(3'b000, 8'h00, 8'h00, 8'h00, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk("arst_valid", bus.validOut, 0);
        chk("arst_af1", bus.almost_full1, 0);
        chk("arst_ovf", bus.overflow_err, 0);
        chk("arst_data", bus.dataOut, 0);
        step();
        step();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(3'b000, 8'h00, 8'h00, 8'h00, 1'b1);
            step();
            chk($sformatf("arst_nostale%0d", i), bus.validOut, 0);
        end
        drive(3'b101, 8'h11, 8'h00, 8'h22, 1'b1);
        step();
        chk("first_grant_wait", bus.validOut, 0);
        drive(3'b000, 8'h00, 8'h00, 8'h00, 1'b1);
        step();
        chk("first_grant_data", bus.dataOut, 8'h11);
        chk("first_grant_lane", bus.laneOut, 0);
        step();
        chk("second_grant_data", bus.dataOut, 8'h22);
        chk("second_grant_lane", bus.laneOut, 2);
        step();
        chk("grant_empty", bus.validOut, 0);

        // Push and pop together on a full lane 2
        for (int i = 0; i < 5; i++) begin
            drive(3'b100, 8'h00, 8'h00, 8'hB0 + 8'(i), 1'b0);
            step();
        end
        chk("full2_filled", bus.full2, 1);
        for (int j = 1; j <= 10; j++) begin
            drive((j <= 6) ? 3'b100 : 3'b000, 8'h00, 8'h00, 8'hB4 + 8'(j), 1'b1);
            step();
            chk($sformatf("pp_data%0d", j), bus.dataOut, 8'hB0 + 8'(j));
            chk($sformatf("pp_lane%0d", j), bus.laneOut, 2);
            if (j <= 6) chk($sformatf("pp_full%0d", j), bus.full2, 1);
            chk($sformatf("pp_ovf%0d", j), bus.overflow_err, 0);
        end
        drive(3'b000, 8'h00, 8'h00, 8'h00, 1'b1);
        step();
        chk("pp_empty", bus.validOut, 0);

        // Pointer wrap on lane 1 with ten back-to-back bytes
        for (int i = 0; i <= 10; i++) begin
            drive((i < 10) ? 3'b010 : 3'b000, 8'h00, 8'(i), 8'h00, 1'b1);
            step();
            if (i >= 1) begin
                chk($sformatf("wrap_valid%0d", i), bus.validOut, 1);
                chk($sformatf("wrap_data%0d", i), bus.dataOut, 8'(i - 1));
                chk($sformatf("wrap_lane%0d", i), bus.laneOut, 1);
            end
        end
        step();
        chk("wrap_empty", bus.validOut, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
